// File: rtl/pipe_stage_elastic.sv
// Elastic inter-stage pipeline register: valid/ready payload of WIDTH bits with an
// optional 2-entry skid buffer, synchronous flush and keep-mask bubble shaping.
module pipe_stage_elastic #(
    parameter int unsigned      WIDTH     = 32,
    parameter logic [WIDTH-1:0] KEEP_MASK = '0,
    parameter int unsigned      SKID      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    // Handshake: a payload moves on any cycle where valid and ready are both high.
    // Valid never waits on ready, and a valid payload stays stable until accepted.

    logic             r_m_valid;
    logic [WIDTH-1:0] r_m_data;
    logic             r_s_valid;
    logic [WIDTH-1:0] r_s_data;

    logic             w_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic [WIDTH-1:0] w_bubble;

    generate
        if (SKID != 0) begin : g_skid_ready
            // Ready comes only from registered state, breaking the out_ready path.
            assign w_in_ready = ~r_s_valid & ~reset;
        end else begin : g_direct_ready
            assign w_in_ready = (~r_m_valid | out_ready) & ~reset;
        end
    endgenerate

    assign w_in_fire  = in_valid & w_in_ready;
    assign w_out_fire = r_m_valid & out_ready;
    assign w_bubble   = in_data & KEEP_MASK;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else if (flush) begin
            r_m_valid <= 1'b0;
            r_m_data  <= w_bubble;
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
        end else if (SKID != 0) begin
            if (!r_m_valid || w_out_fire) begin
                if (r_s_valid) begin
                    // in_ready is low while S is full, so nothing new can arrive here.
                    r_m_valid <= 1'b1;
                    r_m_data  <= r_s_data;
                    r_s_valid <= 1'b0;
                end else if (w_in_fire) begin
                    r_m_valid <= 1'b1;
                    r_m_data  <= in_data;
                end else begin
                    r_m_valid <= 1'b0;
                    r_m_data  <= w_bubble;
                end
            end else if (w_in_fire) begin
                r_s_valid <= 1'b1;
                r_s_data  <= in_data;
            end
        end else begin
            if (w_in_fire) begin
                r_m_valid <= 1'b1;
                r_m_data  <= in_data;
            end else if (w_out_fire) begin
                r_m_valid <= 1'b0;
                r_m_data  <= w_bubble;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_m_valid;
    assign out_data  = r_m_data;
    assign occupancy = {1'b0, r_m_valid} + {1'b0, r_s_valid};

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: a skid instance checked every cycle against a queue
// model, plus a direct-ready instance swept with random traffic.
module tb_pipe_stage_elastic;

    localparam int          W    = 32;
    localparam logic [W-1:0] MASK = 32'h0000FFFF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Skid instance signals
    logic         s_reset, s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [W-1:0] s_in_data, s_out_data;
    logic [1:0]   s_occupancy;

    // Direct-ready instance signals
    logic         n_reset, n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
    logic [W-1:0] n_in_data, n_out_data;
    logic [1:0]   n_occupancy;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    pipe_stage_elastic #(.WIDTH(W), .KEEP_MASK(MASK), .SKID(1)) dut_skid (
        .clk(clk), .reset(s_reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occupancy)
    );

    pipe_stage_elastic #(.WIDTH(W), .KEEP_MASK('0), .SKID(0)) dut_direct (
        .clk(clk), .reset(n_reset), .flush(n_flush),
        .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data),
        .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
        .occupancy(n_occupancy)
    );

    // Reference model of the skid instance: a FIFO of held payloads (capacity 2)
    // plus the bubble pattern shown when nothing is held.
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_bubble = '0;
    logic         m_valid, m_ready, m_fin, m_fout;
    logic [W-1:0] m_data;

    always @(negedge clk) begin
        if (mon_en) begin
            m_valid = (exp_q.size() != 0);
            m_data  = m_valid ? exp_q[0] : m_bubble;
            m_ready = (exp_q.size() < 2) && !s_reset;
            n_checks++;
            if (s_out_valid !== m_valid) begin
                n_fail++;
                $display("FAIL mon_out_valid t=%0t got %b expected %b", $time, s_out_valid, m_valid);
            end
            n_checks++;
            if (s_out_data !== m_data) begin
                n_fail++;
                $display("FAIL mon_out_data t=%0t got %h expected %h", $time, s_out_data, m_data);
            end
            n_checks++;
            if (s_occupancy !== 2'(exp_q.size())) begin
                n_fail++;
                $display("FAIL mon_occupancy t=%0t got %0d expected %0d", $time, s_occupancy, exp_q.size());
            end
            n_checks++;
            if (s_in_ready !== m_ready) begin
                n_fail++;
                $display("FAIL mon_in_ready t=%0t got %b expected %b", $time, s_in_ready, m_ready);
            end
            if (s_reset) begin
                exp_q.delete();
                m_bubble = '0;
            end else begin
                m_fin  = s_in_valid && m_ready;
                m_fout = m_valid && s_out_ready;
                if (s_flush) begin
                    exp_q.delete();
                    m_bubble = s_in_data & MASK;
                end else begin
                    if (m_fout) void'(exp_q.pop_front());
                    if (m_fin) exp_q.push_back(s_in_data);
                    if (exp_q.size() == 0) m_bubble = s_in_data & MASK;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s_reset = 1'b1;
        n_reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0 || s_out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_skid_state got v=%b occ=%0d d=%h expected 0 0 0", s_out_valid, s_occupancy, s_out_data);
        end
        n_checks++;
        if (s_in_ready !== 1'b0 || n_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b/%b expected 0/0", s_in_ready, n_in_ready);
        end
        n_checks++;
        if (n_out_valid !== 1'b0 || n_occupancy !== 2'd0 || n_out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_direct_state got v=%b occ=%0d d=%h expected 0 0 0", n_out_valid, n_occupancy, n_out_data);
        end
        tick();
        s_reset = 1'b0;
        n_reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_in_ready !== 1'b1 || n_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready got %b/%b expected 1/1", s_in_ready, n_in_ready);
        end
    endtask

    task automatic test_streaming();
        logic [W-1:0] vals [3];
        vals = '{32'h11, 32'h22, 32'h33};
        s_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            s_in_valid = 1'b1;
            s_in_data  = vals[i];
            @(negedge clk);
            n_checks++;
            if (s_in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL stream_in_ready[%0d] got %b expected 1", i, s_in_ready);
            end
            if (i > 0) begin
                n_checks++;
                if (s_out_valid !== 1'b1 || s_out_data !== vals[i-1] || s_occupancy !== 2'd1) begin
                    n_fail++;
                    $display("FAIL stream_out[%0d] got v=%b d=%h occ=%0d expected 1 %h 1", i - 1, s_out_valid, s_out_data, s_occupancy, vals[i-1]);
                end
            end
        end
        tick();
        s_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_out_valid !== 1'b1 || s_out_data !== vals[2] || s_occupancy !== 2'd1) begin
            n_fail++;
            $display("FAIL stream_out[2] got v=%b d=%h occ=%0d expected 1 %h 1", s_out_valid, s_out_data, s_occupancy, vals[2]);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0) begin
            n_fail++;
            $display("FAIL stream_drained got v=%b occ=%0d expected 0 0", s_out_valid, s_occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vals [4];
        logic [W-1:0] got_q[$];
        int sent;
        vals = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        sent = 0;
        for (int cyc = 0; cyc < 24 && got_q.size() < 4; cyc++) begin
            tick();
            s_in_valid  = (sent < 4);
            s_in_data   = (sent < 4) ? vals[sent] : '0;
            s_out_ready = (cyc == 0 || cyc >= 5);
            @(negedge clk);
            if (cyc == 1) begin
                n_checks++;
                if (s_out_valid !== 1'b1 || s_out_data !== 32'hA0 || s_in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL bp_first got v=%b d=%h rdy=%b expected 1 a0 1", s_out_valid, s_out_data, s_in_ready);
                end
            end
            if (cyc == 2 || cyc == 3) begin
                n_checks++;
                if (s_occupancy !== 2'd2 || s_in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bp_full[%0d] got occ=%0d rdy=%b expected 2 0", cyc, s_occupancy, s_in_ready);
                end
            end
            if (s_out_valid && s_out_ready) got_q.push_back(s_out_data);
            if (s_in_valid && s_in_ready) sent++;
        end
        n_checks++;
        if (got_q.size() != 4) begin
            n_fail++;
            $display("FAIL bp_count got %0d expected 4", got_q.size());
        end
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            n_checks++;
            if (got_q[i] !== vals[i]) begin
                n_fail++;
                $display("FAIL bp_order[%0d] got %h expected %h", i, got_q[i], vals[i]);
            end
        end
        tick();
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_flush_keep();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hB0;
        tick();
        s_in_data   = 32'hB1;
        tick();
        s_in_valid  = 1'b0;
        s_flush     = 1'b1;
        s_in_data   = 32'hDEAD1234;
        @(negedge clk);
        n_checks++;
        if (s_occupancy !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_pre_occ got %0d expected 2", s_occupancy);
        end
        tick();
        s_flush   = 1'b0;
        s_in_data = 32'hCAFEF00D;
        @(negedge clk);
        n_checks++;
        if (s_out_valid !== 1'b0 || s_occupancy !== 2'd0 || s_out_data !== 32'h00001234 || s_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_keep got v=%b occ=%0d d=%h rdy=%b expected 0 0 00001234 1", s_out_valid, s_occupancy, s_out_data, s_in_ready);
        end
    endtask

    task automatic test_flush_in_fire();
        s_out_ready = 1'b1;
        tick();
        s_flush    = 1'b1;
        s_in_valid = 1'b1;
        s_in_data  = 32'h55;
        @(negedge clk);
        n_checks++;
        if (s_in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_fire_ready got %b expected 1", s_in_ready);
        end
        tick();
        s_flush    = 1'b0;
        s_in_valid = 1'b0;
        s_in_data  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (s_out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_discard[%0d] got v=%b d=%h expected v=0", i, s_out_valid, s_out_data);
            end
            tick();
        end
    endtask

    task automatic test_reset_midstream();
        s_out_ready = 1'b0;
        s_in_valid  = 1'b1;
        s_in_data   = 32'hC0;
        tick();
        s_in_data   = 32'hC1;
        tick();
        s_in_data   = 32'hC2;
        s_reset     = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s_occupancy !== 2'd2 || s_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_pre got occ=%0d rdy=%b expected 2 0", s_occupancy, s_in_ready);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (s_out_valid !== 1'b0 || s_out_data !== '0 || s_occupancy !== 2'd0 || s_in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_clear got v=%b d=%h occ=%0d rdy=%b expected 0 0 0 0", s_out_valid, s_out_data, s_occupancy, s_in_ready);
        end
        tick();
        s_reset    = 1'b0;
        s_in_valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (s_in_ready !== 1'b1 || s_out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_release got rdy=%b v=%b expected 1 0", s_in_ready, s_out_valid);
        end
    endtask

    task automatic test_random_skid();
        for (int i = 0; i < 400; i++) begin
            tick();
            s_in_valid  = ($urandom_range(0, 3) != 0);
            s_in_data   = $urandom;
            s_out_ready = ($urandom_range(0, 2) != 0);
            s_flush     = ($urandom_range(0, 39) == 0);
        end
        tick();
        s_flush     = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_direct_sweep();
        logic [W-1:0] nq[$];
        logic         e_valid, e_ready;
        logic [W-1:0] e_data;
        for (int i = 0; i < 1000; i++) begin
            tick();
            n_in_valid  = ($urandom_range(0, 1) != 0);
            n_in_data   = $urandom;
            n_out_ready = ($urandom_range(0, 1) != 0);
            @(negedge clk);
            e_valid = (nq.size() != 0);
            e_data  = e_valid ? nq[0] : '0;
            e_ready = !e_valid || n_out_ready;
            n_checks++;
            if (n_in_ready !== e_ready) begin
                n_fail++;
                $display("FAIL direct_in_ready[%0d] got %b expected %b", i, n_in_ready, e_ready);
            end
            n_checks++;
            if (n_out_valid !== e_valid || n_out_data !== e_data) begin
                n_fail++;
                $display("FAIL direct_out[%0d] got v=%b d=%h expected %b %h", i, n_out_valid, n_out_data, e_valid, e_data);
            end
            n_checks++;
            if (n_occupancy > 2'd1 || n_occupancy !== 2'(nq.size())) begin
                n_fail++;
                $display("FAIL direct_occupancy[%0d] got %0d expected %0d", i, n_occupancy, nq.size());
            end
            if (e_valid && n_out_ready) void'(nq.pop_front());
            if (n_in_valid && e_ready) nq.push_back(n_in_data);
        end
        tick();
        n_in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_reset = 1'b1; s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
        n_reset = 1'b1; n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_keep();
        test_flush_in_fire();
        test_reset_midstream();
        test_random_skid();
        test_direct_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_elastic.md
Name: pipe_stage_elastic

Overview:
- Parametrised, elastic inter-stage pipeline register for the CPU pipeline (F/D, D/E, E/M, M/W).
- Replaces fixed-field stall/zero stage registers with one valid/ready-handshaked payload of configurable width.
- Optional 2-entry skid buffer, synchronous flush, and bubble data shaping through a keep-mask (for example, PC fields survive a bubble while instruction and operands read zero).

Parameters:
- WIDTH, 32, payload width in bits (callers concatenate fields).
- KEEP_MASK, {WIDTH{1'b0}}, bits of in_data copied into the stage when it holds a bubble; all other bits are forced to 0.
- SKID, 1, 1 selects the 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries.
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a real payload.
- out_ready  in  1  downstream consumes this cycle.
- out_data  out  WIDTH  main-register payload, or bubble pattern when invalid.
- occupancy  out  2  number of valid entries held (0..2; never exceeds 1 when SKID=0).

Behaviour:
- Internal state:
  - Main register M (M_valid, M_data).
  - Skid register S (S_valid, S_data), present only when SKID=1.
  - out_valid = M_valid; out_data = M_data; occupancy = M_valid + S_valid.
- Transfers:
  - in_fire = in_valid & in_ready.
  - out_fire = M_valid & out_ready.
  - in_data is sampled only on in_fire; out_ready is ignored when M_valid=0.
- in_ready:
  - SKID=1: in_ready = ~S_valid & ~reset; no combinational path from out_ready.
  - SKID=0: in_ready = (~M_valid | out_ready) & ~reset.
- Reset (priority 1):
  - M_valid, S_valid, M_data and S_data all become 0; occupancy=0; out_data=0.
  - A reset asserted mid-transfer discards every entry; nothing is replayed.
- Flush (priority 2):
  - Next cycle M_valid=0, S_valid=0, M_data = in_data & KEEP_MASK, S_data=0.
  - Any in_fire in the flush cycle is consumed and discarded.
  - Any out_fire in the flush cycle still completes, since downstream already sampled out_data.
- Normal update, SKID=1, evaluated in order:
  - Case 1, M_valid=0 or out_fire:
    - If S_valid: M <= S, and S <= in_data with valid=in_fire.
    - Else if in_fire: M <= in_data, M_valid=1.
    - Else: M_valid <= 0, M_data <= in_data & KEEP_MASK (bubble).
  - Case 2, M_valid=1 and no out_fire:
    - If in_fire: S <= in_data, S_valid=1.
    - M is held.
  - S is never loaded while S_valid=1, because in_ready is 0 then.
  - FIFO order M before S is always preserved.
- Normal update, SKID=0:
  - in_fire: M <= in_data, M_valid=1.
  - Else out_fire: M_valid <= 0, M_data <= in_data & KEEP_MASK.
  - Else: M is held.
- Latency and throughput:
  - Latency is 1 cycle from in_fire to out_valid.
  - Sustained throughput is 1 payload per cycle with out_ready held high, in both modes.
- Simultaneous in_fire and out_fire with occupancy 1: occupancy stays 1 and M takes the new payload.
- Stall (out_ready=0) with SKID=1:
  - The stage absorbs exactly one extra payload.
  - in_ready falls the cycle after S fills.
- Bubble shape: KEEP_MASK=0 makes invalid out_data all-zero. KEEP_MASK bits reflect in_data from the cycle the bubble was formed.
- No X propagation: every register has a defined reset value; in_data is never captured into M_valid or S_valid.

Test Plan:
- Streaming, WIDTH=32, SKID=1, out_ready=1: send 0x11, 0x22, 0x33 on consecutive cycles -> out_valid on the 3 following cycles with out_data 0x11, 0x22, 0x33; occupancy never exceeds 1.
- Backpressure with SKID=1: stream 0xA0..0xA3 and hold out_ready=0 from the cycle 0xA0 appears -> 0xA1 lands in S; occupancy=2; in_ready=0 the next cycle. Release out_ready -> outputs 0xA0, 0xA1, 0xA2, 0xA3 in order, none lost or duplicated.
- Flush with occupancy=2, KEEP_MASK=0x0000FFFF, in_data=0xDEAD1234 -> next cycle out_valid=0, occupancy=0, out_data=0x00001234, in_ready=1.
- Simultaneous flush and in_fire of 0x55 -> 0x55 never appears at the output.
- Reset asserted mid-stream with occupancy=2 -> next cycle all outputs 0, in_ready=0 during reset and 1 the cycle after release (SKID=1).
- SKID=0 sweep with random in_valid/out_ready over 1000 cycles:
  - in_ready equals ~out_valid | out_ready every cycle.
  - Output sequence equals input sequence.
  - occupancy never exceeds 1.
